retire_map: RTL

// Commit stage directly downstream of the ROB. It consumes the ROB's two retire

---
 rtl/retire_map.sv | 116 +++++++++++
 1 files changed

// File: rtl/retire_map.sv
`default_nettype none
// ============================================================================
// Module   : retire_map
// Purpose  : Two-wide commit stage; keeps the retirement map, frees superseded
//            physical registers, detects halt/illegal, drives branch recovery.
// Revision : 1.0
// ============================================================================
module retire_map #(
    parameter int          PRF_IDX  = 6,
    parameter int          ARF_SZ   = 32,
    parameter int          ZERO_REG = 31,
    parameter logic [31:0] HALT_IR  = 32'h555
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rt1_valid,
    input  logic                        rt2_valid,
    input  logic [2*PRF_IDX-1:0]        rt_pdest,
    input  logic [9:0]                  rt_adest,
    input  logic [63:0]                 rt_ir,
    input  logic [127:0]                rt_npc,
    input  logic [1:0]                  rt_illegal,
    input  logic                        branch_miss,
    input  logic [63:0]                 correct_target,
    output logic [1:0]                  free_valid,
    output logic [2*PRF_IDX-1:0]        free_pidx,
    output logic                        recover,
    output logic [63:0]                 recover_pc,
    output logic [ARF_SZ*PRF_IDX-1:0]   recover_map,
    output logic                        halted,
    output logic                        illegal_halt,
    output logic [63:0]                 halt_pc,
    output logic [63:0]                 retired_cnt
);

    localparam logic [4:0] c_zero = 5'(ZERO_REG);

    logic [PRF_IDX-1:0] r_map [ARF_SZ];

    logic [4:0]         w_a1, w_a2;
    logic [PRF_IDX-1:0] w_p1, w_p2;
    logic               w_halt1, w_halt2;
    logic               w_s1_eff, w_s2_eff;
    logic               w_s1_commit, w_s2_commit;
    logic               w_s1_upd, w_s2_upd;
    logic               w_s1_stop, w_s2_stop;
    logic [PRF_IDX-1:0] w_free1, w_free2;

    always_comb begin
        w_a1    = rt_adest[4:0];
        w_a2    = rt_adest[9:5];
        w_p1    = rt_pdest[PRF_IDX-1:0];
        w_p2    = rt_pdest[2*PRF_IDX-1:PRF_IDX];
        w_halt1 = (rt_ir[31:0] == HALT_IR);
        w_halt2 = (rt_ir[63:32] == HALT_IR);

        w_s1_eff    = rt1_valid && !halted;
        // A branch miss flushes whatever sits in slot 2 this cycle.
        w_s2_eff    = rt2_valid && w_s1_eff && !w_halt1 && !rt_illegal[0] && !branch_miss;
        w_s1_commit = w_s1_eff && !rt_illegal[0];
        w_s2_commit = w_s2_eff && !rt_illegal[1];
        w_s1_upd    = w_s1_commit && (w_a1 != c_zero);
        w_s2_upd    = w_s2_commit && (w_a2 != c_zero);
        w_s1_stop   = w_s1_eff && (w_halt1 || rt_illegal[0]);
        w_s2_stop   = w_s2_eff && (w_halt2 || rt_illegal[1]);

        w_free1 = r_map[w_a1];
        // Same-cycle write to the same register: slot 2 supersedes slot 1's pdest.
        w_free2 = (w_s1_upd && (w_a1 == w_a2)) ? w_p1 : r_map[w_a2];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ARF_SZ; i++) begin
                r_map[i] <= PRF_IDX'(i);
            end
            free_valid   <= '0;
            free_pidx    <= '0;
            recover      <= 1'b0;
            recover_pc   <= '0;
            halted       <= 1'b0;
            illegal_halt <= 1'b0;
            halt_pc      <= '0;
            retired_cnt  <= '0;
        end else begin
            if (w_s1_upd) r_map[w_a1] <= w_p1;
            if (w_s2_upd) r_map[w_a2] <= w_p2;

            free_valid <= {w_s2_upd, w_s1_upd};
            free_pidx  <= {w_s2_upd ? w_free2 : '0, w_s1_upd ? w_free1 : '0};

            recover <= w_s1_commit && branch_miss;
            if (w_s1_commit && branch_miss) recover_pc <= correct_target;

            if (w_s1_stop) begin
                halted       <= 1'b1;
                illegal_halt <= rt_illegal[0];
                halt_pc      <= rt_npc[63:0];
            end else if (w_s2_stop) begin
                halted       <= 1'b1;
                illegal_halt <= rt_illegal[1];
                halt_pc      <= rt_npc[127:64];
            end

            retired_cnt <= retired_cnt + 64'(w_s1_commit) + 64'(w_s2_commit);
        end
    end

    generate
        for (genvar g = 0; g < ARF_SZ; g++) begin : g_map
            assign recover_map[g*PRF_IDX +: PRF_IDX] = r_map[g];
        end
    endgenerate

endmodule
`default_nettype wire
